dmem_responder: RTL and testbench

Multi-cycle data-memory responder serving the core's load/store port over a valid/ready request and response handshake. It models a slow data RAM with a configurable number of wait states. It performs RV32I byte, halfword and word accesses with sign or zero extension on loads and byte-lane writes on stores. It flags misaligned, out-of-range and illegal accesses instead of executing them, letting the core be tested against non-zero memory latency.

---
 rtl/dmem_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Slow data-memory model for the core's load/store port. A request is accepted
// over a valid/ready handshake, the RAM access happens WAIT_CYCLES edges later,
// and the result is held on the response channel until the core takes it.
// Supports RV32I LB/LH/LW/LBU/LHU and SB/SH/SW. Misaligned, out-of-range and
// illegal-funct3 accesses are answered with rsp_err = 1 and do not touch memory.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words stored
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//   WAIT_CYCLES  wait states between acceptance and access (0..15)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   request present
//   req_ready   responder idle and able to accept
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data (byte/half taken from the low bits)
//   req_funct3  RV32I width/sign code
//   rsp_valid   response present
//   rsp_ready   core accepts the response
//   rsp_rdata   load result; 0 for stores and errors
//   rsp_err     access was rejected
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [2:0]  funct3_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  logic [31:0] mem_r [DEPTH_WORDS];

  logic        accept_s;
  logic        access_now_s;
  logic        acc_we_s;
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic [2:0]  acc_funct3_s;
  logic [31:0] acc_off_s;
  logic [IDX_W-1:0] acc_idx_s;
  logic        acc_err_s;
  logic [31:0] acc_word_s;
  logic [31:0] acc_rdata_s;
  logic [3:0]  st_be_s;
  logic [31:0] st_data_s;
  logic        wr_en_s;

  // Any reason the access must be refused: range, alignment or funct3 legality.
  function automatic logic access_err(input logic [31:0] addr,
                                      input logic        we,
                                      input logic [2:0]  f3);
    logic [31:0] off;
    logic        range_err;
    logic        f3_err;
    logic        align_err;
    off       = addr - BASE_ADDR;
    range_err = (addr < BASE_ADDR) || ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));
    case (f3)
      3'b000: begin f3_err = 1'b0; align_err = 1'b0;                end
      3'b001: begin f3_err = 1'b0; align_err = addr[0];             end
      3'b010: begin f3_err = 1'b0; align_err = (addr[1:0] != 2'b00); end
      3'b100: begin f3_err = we;   align_err = 1'b0;                end
      3'b101: begin f3_err = we;   align_err = addr[0];             end
      default: begin f3_err = 1'b1; align_err = 1'b0;               end
    endcase
    return range_err | f3_err | align_err;
  endfunction

  // Little-endian load extraction with sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  a,
                                               input logic [2:0]  f3);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {a, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b010:  res = word;
      3'b100:  res = {24'd0, sh[7:0]};
      3'b101:  res = {16'd0, sh[15:0]};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  assign req_ready = (state_r == IDLE) && !rst;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  assign accept_s = req_valid && req_ready;

  // Access happens either at the accepting edge (no wait states) or when the
  // wait counter runs out; with no wait states the request is taken live.
  always_comb begin
    access_now_s = 1'b0;
    acc_we_s     = we_r;
    acc_addr_s   = addr_r;
    acc_wdata_s  = wdata_r;
    acc_funct3_s = funct3_r;
    if (state_r == IDLE) begin
      access_now_s = accept_s && (WAIT_CYCLES == 0);
      acc_we_s     = req_we;
      acc_addr_s   = req_addr;
      acc_wdata_s  = req_wdata;
      acc_funct3_s = req_funct3;
    end else if (state_r == WAIT) begin
      access_now_s = (cnt_r == 4'd0);
    end else begin
      access_now_s = 1'b0;
    end
  end

  // Address decode, read path and store lane selection for the current access.
  always_comb begin
    acc_off_s   = acc_addr_s - BASE_ADDR;
    acc_idx_s   = acc_off_s[IDX_W+1:2];
    acc_err_s   = access_err(acc_addr_s, acc_we_s, acc_funct3_s);
    acc_word_s  = mem_r[acc_idx_s];
    if (acc_err_s || acc_we_s) begin
      acc_rdata_s = 32'd0;
    end else begin
      acc_rdata_s = load_extract(acc_word_s, acc_addr_s[1:0], acc_funct3_s);
    end
    case (acc_funct3_s)
      3'b000: begin
        st_be_s   = 4'b0001 << acc_addr_s[1:0];
        st_data_s = {4{acc_wdata_s[7:0]}};
      end
      3'b001: begin
        st_be_s   = acc_addr_s[1] ? 4'b1100 : 4'b0011;
        st_data_s = {2{acc_wdata_s[15:0]}};
      end
      3'b010: begin
        st_be_s   = 4'b1111;
        st_data_s = acc_wdata_s;
      end
      default: begin
        st_be_s   = 4'b0000;
        st_data_s = 32'd0;
      end
    endcase
    wr_en_s = access_now_s && acc_we_s && !acc_err_s && !rst;
  end

  // RAM array: byte-lane writes, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be_s[b]) begin
          mem_r[acc_idx_s][8*b +: 8] <= st_data_s[8*b +: 8];
        end
      end
    end
  end

  // Request/response sequencing with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      funct3_r    <= 3'd0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r     <= req_we;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            funct3_r <= req_funct3;
            if (WAIT_CYCLES == 0) begin
              rsp_rdata_r <= acc_rdata_s;
              rsp_err_r   <= acc_err_s;
              rsp_valid_r <= 1'b1;
              state_r     <= RESP;
            end else begin
              cnt_r   <= 4'(WAIT_CYCLES - 1);
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            rsp_rdata_r <= acc_rdata_s;
            rsp_err_r   <= acc_err_s;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          // Outputs stay frozen until the core takes the response.
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests;
  int fails;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR(32'h0000_0000),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_funct3(req_funct3),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, measure cycles until rsp_valid, capture and accept it.
  // lat = -1 means the request was not accepted or no response within budget.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, output int lat, output logic [31:0] rdata,
                     output logic err);
    logic was_ready;
    lat = -1;
    rdata = 32'hxxxx_xxxx;
    err = 1'bx;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_funct3 = f3;
    was_ready = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hA5A5_A5A5;
    req_addr = 32'hFFFF_FFFC;
    if (was_ready === 1'b1) begin
      for (int c = 1; c <= 20; c++) begin
        if (rsp_valid === 1'b1) break;
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) begin
          lat = c;
          rdata = rsp_rdata;
          err = rsp_err;
        end
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_rdata, rsp_err, req_ready} !== {1'b0, 32'd0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset_hold: valid=%b rdata=%h err=%b ready=%b, want 0/0/0/0",
                 rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_release: ready=%b valid=%b rdata=%h err=%b, want 1/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er;
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, lat, rd, er);
    tests++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
      fails++;
      $display("FAIL sw_10: lat=%0d err=%b rdata=%h, want 2/0/00000000", lat, er, rd);
    end
    txn(1'b0, 32'h10, 32'd0, 3'b010, lat, rd, er);
    tests++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL lw_10: lat=%0d err=%b rdata=%h, want 2/0/deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_subword();
    int lat; logic [31:0] rd; logic er;
    logic        we_v [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad_v [6]  = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11, 32'h10};
    logic [31:0] wd_v [6]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hAAAA_AA55, 32'd0};
    logic [2:0]  f3_v [6]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] ex_v [6]  = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD,
                               32'h0000_BEEF, 32'h0000_0000, 32'hDEAD_55EF};
    for (int i = 0; i < 6; i++) begin
      txn(we_v[i], ad_v[i], wd_v[i], f3_v[i], lat, rd, er);
      tests++;
      if (lat !== 2 || er !== 1'b0 || rd !== ex_v[i]) begin
        fails++;
        $display("FAIL subword_%0d: lat=%0d err=%b rdata=%h, want 2/0/%h", i, lat, er, rd, ex_v[i]);
      end
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    logic        we_v [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad_v [6] = '{32'h12, 32'h13, 32'h1000, 32'h10, 32'h11, 32'h10};
    logic [31:0] wd_v [6] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'h0, 32'd0, 32'd0};
    logic [2:0]  f3_v [6] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b011};
    for (int i = 0; i < 6; i++) begin
      txn(we_v[i], ad_v[i], wd_v[i], f3_v[i], lat, rd, er);
      tests++;
      if (lat !== 2 || er !== 1'b1 || rd !== 32'd0) begin
        fails++;
        $display("FAIL err_%0d: lat=%0d err=%b rdata=%h, want 2/1/00000000", i, lat, er, rd);
      end
    end
    txn(1'b0, 32'h10, 32'd0, 3'b010, lat, rd, er);
    tests++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEAD_55EF) begin
      fails++;
      $display("FAIL err_mem_intact: lat=%0d err=%b rdata=%h, want 2/0/dead55ef", lat, er, rd);
    end
  endtask

  task automatic test_backpressure();
    int waited;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    tests++;
    if (waited !== 2) begin
      fails++;
      $display("FAIL bp_latency: cycles=%0d, want 2", waited);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = i[0] ? 1'b0 : 1'b1;
      req_addr = 32'h20;
      tests++;
      if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b1, 1'b0, 32'hDEAD_55EF, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold_%0d: valid=%b err=%b rdata=%h ready=%b, want 1/0/dead55ef/0",
                 i, rsp_valid, rsp_err, rsp_rdata, req_ready);
      end
    end
    @(negedge clk);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    tests++;
    if ({req_ready, rsp_valid} !== {1'b1, 1'b0}) begin
      fails++;
      $display("FAIL bp_release: ready=%b valid=%b, want 1/0", req_ready, rsp_valid);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, req_ready} !== {1'b0, 1'b1}) begin
        fails++;
        $display("FAIL bp_no_queue_%0d: valid=%b ready=%b, want 0/1", i, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er;
    txn(1'b1, 32'h20, 32'h0, 3'b010, lat, rd, er);
    tests++;
    if (lat !== 2 || er !== 1'b0) begin
      fails++;
      $display("FAIL mid_init: lat=%0d err=%b, want 2/0", lat, er);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_wdata = 32'h1234_5678; req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({rsp_valid, req_ready} !== {1'b0, 1'b0}) begin
      fails++;
      $display("FAIL mid_in_reset: valid=%b ready=%b, want 0/0", rsp_valid, req_ready);
    end
    rst = 1'b0;
    txn(1'b0, 32'h20, 32'd0, 3'b010, lat, rd, er);
    tests++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
      fails++;
      $display("FAIL mid_dropped: lat=%0d err=%b rdata=%h, want 2/0/00000000", lat, er, rd);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    req_funct3 = 3'd0;
    rsp_ready = 1'b0;
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
